// File: rtl/l0_pkg.sv
// Shared definitions for the L0 skew bank: read-mode encodings, mode FSM states
// and the pointer-width helper used by the row FIFOs.
package l0_pkg;

    localparam logic L0_MODE_PAR  = 1'b0;
    localparam logic L0_MODE_SKEW = 1'b1;

    typedef enum logic [0:0] {
        StIdle  = 1'b0,
        StDrain = 1'b1
    } l0_state_e;

    // Pointer width: index bits plus one wrap bit.
    function automatic int unsigned l0_ptr_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/l0_row_fifo.sv
// One row of the L0 bank: circular buffer with wrap-bit pointers, an occupancy
// count taken from the registered pointers, and a registered output slot that
// is refreshed only on a successful pop.
module l0_row_fifo
    import l0_pkg::*;
#(
    parameter int unsigned BW    = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic [BW-1:0]          data_i,
    output logic [BW-1:0]          data_o,
    output logic                   valid_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = l0_ptr_w(DEPTH);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [BW-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic [BW-1:0] mem_q [DEPTH];
    logic          empty;
    logic          do_pop;

    // Empty comes from registered pointers, so a same-cycle push never falls through.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_pop  = pop_i && !empty;
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

    // Next-state for pointers and the output slot.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        if (push_i) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            data_d   = mem_q[rd_ptr_q[AW-1:0]];
            valid_d  = 1'b1;
        end
    end

    // Pointer and output registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
        end
    end

    // Storage array; contents are meaningless once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (push_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/l0_skew_bank.sv
// L0 input buffer: ROW row FIFOs written in parallel, drained toward the array
// either all rows at once or with row i lagging row i-1 by one cycle.
// Optional feature macro: L0_ERR_FLAG_EN adds sticky o_ovf / o_udf flags.
module l0_skew_bank
    import l0_pkg::*;
#(
    parameter int unsigned ROW   = 8,
    parameter int unsigned BW    = 4,
    parameter int unsigned DEPTH = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ROW*BW-1:0]      in,
    input  logic                   wr,
    input  logic                   rd,
    input  logic                   mode,
    output logic [ROW*BW-1:0]      out,
    output logic [ROW-1:0]         o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_occ
`ifdef L0_ERR_FLAG_EN
    ,
    output logic                   o_ovf,
    output logic                   o_udf
`endif
);

    localparam int unsigned PW = l0_ptr_w(DEPTH);

    logic [ROW-1:0] rd_en_q, rd_en_d;
    logic           mode_q, mode_d;
    l0_state_e      state_q, state_d;
    logic [PW-1:0]  count_r [ROW];
    logic [ROW-1:0] full_r;
    logic [ROW-1:0] empty_r;
    logic           push;

    // A word is accepted only if every row has room; otherwise it is dropped whole.
    assign push = wr && !o_full;

    for (genvar g = 0; g < ROW; g++) begin : g_row
        l0_row_fifo #(
            .BW    (BW),
            .DEPTH (DEPTH)
        ) u_fifo (
            .clk_i   (clk),
            .rst_ni  (reset),
            .push_i  (push),
            .pop_i   (rd_en_q[g]),
            .data_i  (in[BW*g +: BW]),
            .data_o  (out[BW*g +: BW]),
            .valid_o (o_valid[g]),
            .count_o (count_r[g])
        );
        // Count never exceeds DEPTH, so its MSB alone marks a full row.
        assign full_r[g]  = count_r[g][PW-1];
        assign empty_r[g] = (count_r[g] == '0);
    end

    assign o_full  = |full_r;
    assign o_ready = !o_full;
    assign o_empty = &empty_r;
    assign o_occ   = count_r[0];

    // Read-wave generation and mode latching; mode only changes while no wave is in flight.
    always_comb begin
        rd_en_d = {ROW{rd}};
        if (mode_q == L0_MODE_SKEW) begin
            rd_en_d = {rd_en_q[ROW-2:0], rd};
        end
        mode_d = mode_q;
        if (state_q == StIdle) begin
            mode_d = mode;
        end
        state_d = (rd_en_d != '0) ? StDrain : StIdle;
    end

    // Mode FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_en_q <= '0;
            mode_q  <= L0_MODE_PAR;
            state_q <= StIdle;
        end else begin
            rd_en_q <= rd_en_d;
            mode_q  <= mode_d;
            state_q <= state_d;
        end
    end

`ifdef L0_ERR_FLAG_EN
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    // Sticky flags: dropped writes and read requests that hit an empty row.
    always_comb begin
        ovf_d = ovf_q | (wr && o_full);
        udf_d = udf_q | (|(rd_en_q & empty_r));
    end

    // Error flag registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            udf_q <= udf_d;
        end
    end

    assign o_ovf = ovf_q;
    assign o_udf = udf_q;
`endif

endmodule

// File: tb/tb_l0_skew_bank.sv
// Self-checking bench for l0_skew_bank. A queue-based model tracks stored words,
// per-row pop counts and the cycle at which each row is asked to pop.
module tb_l0_skew_bank;

    localparam int ROW   = 8;
    localparam int BW    = 4;
    localparam int DEPTH = 64;
    localparam int OW    = $clog2(DEPTH) + 1;
    localparam int NC    = 8192;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [ROW*BW-1:0] din;
    logic [ROW*BW-1:0] dout;
    logic              wr, rd, mode;
    logic [ROW-1:0]    valid;
    logic              full, ready, empty;
    logic [OW-1:0]     occ;
`ifdef L0_ERR_FLAG_EN
    logic              ovf, udf;
`endif

    l0_skew_bank #(
        .ROW   (ROW),
        .BW    (BW),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .in      (din),
        .wr      (wr),
        .rd      (rd),
        .mode    (mode),
        .out     (dout),
        .o_valid (valid),
        .o_full  (full),
        .o_ready (ready),
        .o_empty (empty),
        .o_occ   (occ)
`ifdef L0_ERR_FLAG_EN
        ,
        .o_ovf   (ovf),
        .o_udf   (udf)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state.
    logic [ROW*BW-1:0] wq[$];
    int                popped [ROW];
    logic [ROW-1:0]    req_at [NC];
    logic [ROW*BW-1:0] m_out;
    logic [ROW-1:0]    m_valid;
    logic              m_mode, m_ovf, m_udf;
    int                cyc;

    function automatic void model_reset();
        wq.delete();
        for (int i = 0; i < ROW; i++) popped[i] = 0;
        for (int c = 0; c < NC; c++) req_at[c] = '0;
        m_out   = '0;
        m_valid = '0;
        m_mode  = 1'b0;
        m_ovf   = 1'b0;
        m_udf   = 1'b0;
        cyc     = 0;
    endfunction

    function automatic int m_size(input int r);
        return wq.size() - popped[r];
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < ROW; i++) if (m_size(i) >= DEPTH) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic m_empty();
        for (int i = 0; i < ROW; i++) if (m_size(i) != 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_busy();
        for (int k = 0; k <= ROW; k++) if (req_at[cyc+k] != '0) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the model, using the inputs currently driven.
    function automatic void model_edge();
        logic [ROW-1:0]    req;
        logic              any_full;
        logic [ROW*BW-1:0] w;
        req      = req_at[cyc];
        any_full = m_full();
        m_valid  = '0;
        for (int i = 0; i < ROW; i++) begin
            if (req[i]) begin
                if (m_size(i) > 0) begin
                    w = wq[popped[i]];
                    m_out[i*BW +: BW] = w[i*BW +: BW];
                    popped[i]++;
                    m_valid[i] = 1'b1;
                end else begin
                    m_udf = 1'b1;
                end
            end
        end
        if (wr) begin
            if (any_full) m_ovf = 1'b1;
            else wq.push_back(din);
        end
        if (rd) begin
            if (m_mode) begin
                for (int i = 0; i < ROW; i++) req_at[cyc+1+i][i] = 1'b1;
            end else begin
                req_at[cyc+1] = '1;
            end
        end
        if (req == '0) m_mode = mode;
        cyc++;
    endfunction

    task automatic step(input logic w, input logic r, input logic m,
                        input logic [ROW*BW-1:0] d);
        wr   = w;
        rd   = r;
        mode = m;
        din  = d;
        @(posedge clk);
        if (cyc > NC - 2*ROW - 4) begin
            $display("FAIL model_range cyc=%0d got overflow want in range", cyc);
            $fatal(1, "model cycle range exceeded");
        end
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        mode  = 1'b0;
        din   = '0;
        model_reset();
        #12;
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL rst_ready got %b want 1", ready); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got %b want 1", empty); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got %b want 0", full); end
        total++; if (occ !== '0) begin bad++; $display("FAIL rst_occ got %0d want 0", occ); end
        total++; if (valid !== '0) begin bad++; $display("FAIL rst_valid got %b want 0", valid); end
        total++; if (dout !== '0) begin bad++; $display("FAIL rst_out got %h want 0", dout); end
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (valid !== '0) begin bad++; $display("FAIL rst_idle_valid got %b want 0", valid); end
        total++; if (occ !== '0) begin bad++; $display("FAIL rst_idle_occ got %0d want 0", occ); end
    endtask

    task automatic test_parallel();
        logic [ROW*BW-1:0] w;
        int waves;
        waves = 0;
        step(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < ROW; i++) w[i*BW +: BW] = BW'(i + k);
            step(1'b1, 1'b0, 1'b0, w);
        end
        total++; if (occ !== OW'(3)) begin bad++; $display("FAIL par_occ got %0d want 3", occ); end
        for (int c = 0; c < 8; c++) begin
            step(1'b0, c < 3, 1'b0, '0);
            total++; if (valid !== m_valid) begin bad++; $display("FAIL par_valid cyc=%0d got %b want %b", cyc, valid, m_valid); end
            if (valid == '1) begin
                for (int i = 0; i < ROW; i++) w[i*BW +: BW] = BW'(i + waves);
                total++; if (dout !== w) begin bad++; $display("FAIL par_data wave=%0d got %h want %h", waves, dout, w); end
                waves++;
            end
        end
        total++; if (waves !== 3) begin bad++; $display("FAIL par_waves got %0d want 3", waves); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL par_empty got %b want 1", empty); end
    endtask

    task automatic test_skew();
        logic [ROW*BW-1:0] w;
        logic [ROW-1:0]    ev;
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        w = $urandom;
        step(1'b1, 1'b0, 1'b1, w);
        step(1'b0, 1'b1, 1'b1, '0);
        for (int j = 1; j <= ROW + 2; j++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            ev = (j <= ROW) ? (ROW'(1) << (j - 1)) : '0;
            total++; if (valid !== ev) begin bad++; $display("FAIL skew_walk j=%0d got %b want %b", j, valid, ev); end
            total++; if (dout !== m_out) begin bad++; $display("FAIL skew_out j=%0d got %h want %h", j, dout, m_out); end
            if (j <= ROW) begin
                total++;
                if (dout[(j-1)*BW +: BW] !== w[(j-1)*BW +: BW]) begin
                    bad++;
                    $display("FAIL skew_data row=%0d got %h want %h", j - 1, dout[(j-1)*BW +: BW], w[(j-1)*BW +: BW]);
                end
            end
        end
    endtask

    task automatic test_full_wrap();
        logic [ROW*BW-1:0] words [DEPTH];
        int n;
        step(1'b0, 1'b0, 1'b0, '0);
        for (int k = 0; k < DEPTH; k++) begin
            words[k] = $urandom;
            step(1'b1, 1'b0, 1'b0, words[k]);
        end
        total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full got %b want 1", full); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL fill_ready got %b want 0", ready); end
        total++; if (occ !== OW'(DEPTH)) begin bad++; $display("FAIL fill_occ got %0d want %0d", occ, DEPTH); end
        step(1'b1, 1'b0, 1'b0, '1);
        total++; if (occ !== OW'(DEPTH)) begin bad++; $display("FAIL drop_occ got %0d want %0d", occ, DEPTH); end
`ifdef L0_ERR_FLAG_EN
        total++; if (ovf !== 1'b1) begin bad++; $display("FAIL drop_ovf got %b want 1", ovf); end
`endif
        n = 0;
        for (int c = 0; c < DEPTH + 3; c++) begin
            step(1'b0, c < DEPTH, 1'b0, '0);
            total++; if (dout !== m_out) begin bad++; $display("FAIL drain_out cyc=%0d got %h want %h", cyc, dout, m_out); end
            if (valid == '1 && n < DEPTH) begin
                total++; if (dout !== words[n]) begin bad++; $display("FAIL drain_order n=%0d got %h want %h", n, dout, words[n]); end
                n++;
            end
        end
        total++; if (n !== DEPTH) begin bad++; $display("FAIL drain_count got %0d want %0d", n, DEPTH); end
        total++; if (occ !== '0) begin bad++; $display("FAIL drain_occ got %0d want 0", occ); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL drain_empty got %b want 1", empty); end
    endtask

    task automatic test_empty_rd();
        logic [ROW*BW-1:0] w;
        step(1'b0, 1'b1, 1'b0, '0);
        for (int c = 0; c < 3; c++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            total++; if (valid !== '0) begin bad++; $display("FAIL erd_valid c=%0d got %b want 0", c, valid); end
        end
`ifdef L0_ERR_FLAG_EN
        total++; if (udf !== 1'b1) begin bad++; $display("FAIL erd_udf got %b want 1", udf); end
`endif
        // Read wave arrives in the same cycle as the first push into an empty bank.
        w = $urandom;
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b1, 1'b0, 1'b0, w);
        total++; if (occ !== OW'(1)) begin bad++; $display("FAIL wrrd_occ got %0d want 1", occ); end
        total++; if (valid !== '0) begin bad++; $display("FAIL wrrd_valid got %b want 0", valid); end
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (valid !== '0) begin bad++; $display("FAIL wrrd_hold got %b want 0", valid); end
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (valid !== '1) begin bad++; $display("FAIL wrrd_pop got %b want all", valid); end
        total++; if (dout !== w) begin bad++; $display("FAIL wrrd_data got %h want %h", dout, w); end
        total++; if (occ !== '0) begin bad++; $display("FAIL wrrd_occ_end got %0d want 0", occ); end
    endtask

    task automatic test_mode_toggle();
        logic [ROW*BW-1:0] w0, w1;
        logic [ROW-1:0]    ev;
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        w0 = $urandom;
        w1 = $urandom;
        step(1'b1, 1'b0, 1'b1, w0);
        step(1'b1, 1'b0, 1'b1, w1);
        step(1'b0, 1'b1, 1'b1, '0);
        // Mode flips to parallel while the skewed wave is still walking.
        for (int j = 1; j <= ROW + 2; j++) begin
            step(1'b0, 1'b0, 1'b0, '0);
            ev = (j <= ROW) ? (ROW'(1) << (j - 1)) : '0;
            total++; if (valid !== ev) begin bad++; $display("FAIL tog_walk j=%0d got %b want %b", j, valid, ev); end
            total++; if (valid !== m_valid) begin bad++; $display("FAIL tog_model j=%0d got %b want %b", j, valid, m_valid); end
        end
        total++; if (dout !== w0) begin bad++; $display("FAIL tog_data0 got %h want %h", dout, w0); end
        step(1'b0, 1'b1, 1'b0, '0);
        step(1'b0, 1'b0, 1'b0, '0);
        total++; if (valid !== '1) begin bad++; $display("FAIL tog_par got %b want all", valid); end
        total++; if (dout !== w1) begin bad++; $display("FAIL tog_data1 got %h want %h", dout, w1); end
    endtask

    task automatic test_random();
        logic m, r, w;
        m = m_mode;
        for (int s = 0; s < 300; s++) begin
            r = ($urandom_range(0, 99) < 30);
            w = ($urandom_range(0, 99) < 55);
            if (!m_busy() && $urandom_range(0, 5) == 0) begin
                m = ~m;
                r = 1'b0;
            end
            step(w, r, m, $urandom);
            total++; if (valid !== m_valid) begin bad++; $display("FAIL rnd_valid cyc=%0d got %b want %b", cyc, valid, m_valid); end
            total++; if (dout !== m_out) begin bad++; $display("FAIL rnd_out cyc=%0d got %h want %h", cyc, dout, m_out); end
            total++; if (occ !== OW'(m_size(0))) begin bad++; $display("FAIL rnd_occ cyc=%0d got %0d want %0d", cyc, occ, m_size(0)); end
            total++; if (full !== m_full()) begin bad++; $display("FAIL rnd_full cyc=%0d got %b want %b", cyc, full, m_full()); end
            total++; if (empty !== m_empty()) begin bad++; $display("FAIL rnd_empty cyc=%0d got %b want %b", cyc, empty, m_empty()); end
`ifdef L0_ERR_FLAG_EN
            total++; if (ovf !== m_ovf) begin bad++; $display("FAIL rnd_ovf cyc=%0d got %b want %b", cyc, ovf, m_ovf); end
            total++; if (udf !== m_udf) begin bad++; $display("FAIL rnd_udf cyc=%0d got %b want %b", cyc, udf, m_udf); end
`endif
        end
    endtask

    task automatic test_async_reset();
        for (int c = 0; c < ROW + 4; c++) step(1'b0, 1'b0, 1'b1, '0);
        step(1'b1, 1'b0, 1'b1, $urandom);
        step(1'b1, 1'b0, 1'b1, $urandom);
        step(1'b0, 1'b1, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        step(1'b0, 1'b0, 1'b1, '0);
        total++; if (valid !== m_valid) begin bad++; $display("FAIL ar_pre got %b want %b", valid, m_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        total++; if (valid !== '0) begin bad++; $display("FAIL ar_valid got %b want 0", valid); end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_empty got %b want 1", empty); end
        total++; if (dout !== '0) begin bad++; $display("FAIL ar_out got %h want 0", dout); end
        total++; if (occ !== '0) begin bad++; $display("FAIL ar_occ got %0d want 0", occ); end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < ROW + 2; c++) begin
            step(1'b0, 1'b0, 1'b1, '0);
            total++; if (valid !== '0) begin bad++; $display("FAIL ar_after c=%0d got %b want 0", c, valid); end
        end
        total++; if (empty !== 1'b1) begin bad++; $display("FAIL ar_after_empty got %b want 1", empty); end
    endtask

    initial begin
        test_reset();
        test_parallel();
        test_skew();
        test_full_wrap();
        test_empty_rd();
        test_mode_toggle();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
